// File: rtl/vga_pkg.sv
// Default 800x600@60 raster constants and a width-independent per-axis mode description.
package vga_pkg;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } axis_mode_t;

   localparam axis_mode_t DEF_H_MODE = '{active: 800, fp: 40, sync: 128, bp: 88};
   localparam axis_mode_t DEF_V_MODE = '{active: 600, fp: 1, sync: 4, bp: 23};
   localparam int unsigned DEF_CNT_W = 11;

   function automatic int unsigned mode_total(input axis_mode_t m);
      return m.active + m.fp + m.sync + m.bp;
   endfunction

   localparam int unsigned DEF_H_TOT = mode_total(DEF_H_MODE);
   localparam int unsigned DEF_V_TOT = mode_total(DEF_V_MODE);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus sync/blank/last strobes, all registered from next-state count.
// Latency 1 clk after an advancing edge; no backpressure, en&inc low holds every register.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned TOT        = DEF_H_TOT,
   parameter int unsigned ACTIVE     = DEF_H_MODE.active,
   parameter int unsigned SYNC_START = DEF_H_MODE.active + DEF_H_MODE.fp,
   parameter int unsigned SYNC_LEN   = DEF_H_MODE.sync,
   parameter bit          POL        = 1'b1,
   parameter int unsigned W          = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         sync,
   output logic         blnk,
   output logic         last
);

   localparam logic [W-1:0] LAST_C   = W'(TOT - 1);
   localparam logic [W-1:0] ACTIVE_C = W'(ACTIVE);
   localparam logic [W-1:0] SS_C     = W'(SYNC_START);
   localparam logic [W-1:0] SE_C     = W'(SYNC_START + SYNC_LEN - 1);

   logic         adv;
   logic [W-1:0] count_nxt;

   always_comb begin
      adv       = en & inc;
      count_nxt = count;
      if (adv) begin
         count_nxt = (count == LAST_C) ? '0 : count + W'(1);
      end
   end

   // Strobes derive from count_nxt so they land in the same cycle as the count they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         sync  <= !POL;
         blnk  <= 1'b0;
         last  <= 1'b0;
      end else if (adv) begin
         count <= count_nxt;
         sync  <= (count_nxt >= SS_C && count_nxt <= SE_C) ? POL : !POL;
         blnk  <= (count_nxt >= ACTIVE_C);
         last  <= (count_nxt == LAST_C);
      end
   end

endmodule

// File: rtl/vga_timing_param.sv
// Mode-agnostic VGA raster source: h/v counters, sync, blank and line/frame strobes, latency 1 pclk, zero skew.
// No backpressure: en low freezes all state. Optional frame counter: VGA_TIMING_FRAME_CNT_EN.
module vga_timing_param
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = DEF_H_MODE.active,
   parameter int unsigned H_FP      = DEF_H_MODE.fp,
   parameter int unsigned H_SYNC    = DEF_H_MODE.sync,
   parameter int unsigned H_BP      = DEF_H_MODE.bp,
   parameter int unsigned V_ACTIVE  = DEF_V_MODE.active,
   parameter int unsigned V_FP      = DEF_V_MODE.fp,
   parameter int unsigned V_SYNC    = DEF_V_MODE.sync,
   parameter int unsigned V_BP      = DEF_V_MODE.bp,
   parameter bit          HSYNC_POL = 1'b1,
   parameter bit          VSYNC_POL = 1'b1,
   parameter int unsigned CNT_W     = DEF_CNT_W
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             hblnk,
   output logic             vblnk,
   output logic             end_of_line,
   output logic             end_of_frame
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);

   localparam int unsigned H_TOT = mode_total('{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP});
   localparam int unsigned V_TOT = mode_total('{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP});
   localparam logic [CNT_W-1:0] H_PRE_LAST = CNT_W'(H_TOT - 2);

   logic v_last;

   vga_axis_counter #(
      .TOT(H_TOT), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP),
      .SYNC_LEN(H_SYNC), .POL(HSYNC_POL), .W(CNT_W)
   ) u_h (
      .clk(pclk), .rst_n(rst_n), .en(en), .inc(1'b1),
      .count(hcount), .sync(hsync), .blnk(hblnk), .last(end_of_line)
   );

   vga_axis_counter #(
      .TOT(V_TOT), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP),
      .SYNC_LEN(V_SYNC), .POL(VSYNC_POL), .W(CNT_W)
   ) u_v (
      .clk(pclk), .rst_n(rst_n), .en(en), .inc(end_of_line),
      .count(vcount), .sync(vsync), .blnk(vblnk), .last(v_last)
   );

   // Next pixel is the final one of the frame when h is one short of its last and v already sits on its last.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         end_of_frame <= 1'b0;
      end else if (en) begin
         end_of_frame <= (hcount == H_PRE_LAST) && v_last;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if (en && end_of_line && v_last) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: a small-mode instance and a default 800x600 active-low-sync instance
// checked cycle by cycle against a raster model through a scoreboard, plus per-scenario inline checks.
module tb_vga_timing_param;

   localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 6, SHT = 32;
   localparam int SVA = 10, SVF = 1, SVS = 2, SVB = 3, SVT = 16;
   localparam int DHA = 800, DHF = 40, DHS = 128, DHB = 88, DHT = 1056;
   localparam int DVA = 600, DVF = 1, DVS = 4, DVB = 23, DVT = 628;
`ifdef VGA_TIMING_FRAME_CNT_EN
   localparam bit FC_ON = 1'b1;
`else
   localparam bit FC_ON = 1'b0;
`endif

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic        eol;
      logic        eof;
      logic [15:0] fc;
   } obs_t;

   localparam obs_t RST_S = '{h: 11'd0, v: 11'd0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0,
                              eol: 1'b0, eof: 1'b0, fc: 16'd0};
   localparam obs_t RST_D = '{h: 11'd0, v: 11'd0, hs: 1'b1, vs: 1'b1, hb: 1'b0, vb: 1'b0,
                              eol: 1'b0, eof: 1'b0, fc: 16'd0};

   logic pclk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;

   logic [10:0] s_h, s_v, d_h, d_v;
   logic s_hs, s_vs, s_hb, s_vb, s_eol, s_eof;
   logic d_hs, d_vs, d_hb, d_vb, d_eol, d_eof;
   logic [15:0] s_fc, d_fc;
   obs_t s_obs, d_obs;

   obs_t sq[$];
   obs_t dq[$];
   int vectors = 0;
   int miscompares = 0;
   int sh = 0, sv = 0, sfc = 0;
   int dh = 0, dv = 0, dfc = 0;

   always #5 pclk = ~pclk;

   vga_timing_param #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(11)
   ) dut (
      .pclk(pclk), .rst_n(rst_n), .en(en),
      .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs),
      .hblnk(s_hb), .vblnk(s_vb), .end_of_line(s_eol), .end_of_frame(s_eof)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(s_fc)
`endif
   );

   vga_timing_param #(
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
   ) dut_neg (
      .pclk(pclk), .rst_n(rst_n), .en(en),
      .hcount(d_h), .vcount(d_v), .hsync(d_hs), .vsync(d_vs),
      .hblnk(d_hb), .vblnk(d_vb), .end_of_line(d_eol), .end_of_frame(d_eof)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(d_fc)
`endif
   );

`ifndef VGA_TIMING_FRAME_CNT_EN
   assign s_fc = 16'd0;
   assign d_fc = 16'd0;
`endif

   always_comb begin
      s_obs = '{h: s_h, v: s_v, hs: s_hs, vs: s_vs, hb: s_hb, vb: s_vb, eol: s_eol, eof: s_eof, fc: s_fc};
      d_obs = '{h: d_h, v: d_v, hs: d_hs, vs: d_vs, hb: d_hb, vb: d_vb, eol: d_eol, eof: d_eof, fc: d_fc};
   end

   function automatic obs_t model(input int h, input int v, input int ha, input int hf, input int hs,
                                  input int va, input int vf, input int vs, input int ht, input int vt,
                                  input bit hp, input bit vp, input int fc);
      obs_t o;
      o.h   = 11'(h);
      o.v   = 11'(v);
      o.hs  = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
      o.vs  = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
      o.hb  = (h >= ha);
      o.vb  = (v >= va);
      o.eol = (h == ht - 1);
      o.eof = (h == ht - 1) && (v == vt - 1);
      o.fc  = FC_ON ? 16'(fc) : 16'h0;
      return o;
   endfunction

   task automatic adv(inout int h, inout int v, inout int fc, input int ht, input int vt);
      if (h == ht - 1) begin
         h = 0;
         if (v == vt - 1) begin
            v = 0;
            fc = (fc + 1) % 65536;
         end else begin
            v = v + 1;
         end
      end else begin
         h = h + 1;
      end
   endtask

   // Drive one cycle of en and queue the state both instances must show after the next edge.
   task automatic step(input logic e);
      en = e;
      if (e) begin
         adv(sh, sv, sfc, SHT, SVT);
         adv(dh, dv, dfc, DHT, DVT);
      end
      sq.push_back(model(sh, sv, SHA, SHF, SHS, SVA, SVF, SVS, SHT, SVT, 1'b1, 1'b1, sfc));
      dq.push_back(model(dh, dv, DHA, DHF, DHS, DVA, DVF, DVS, DHT, DVT, 1'b0, 1'b0, dfc));
      @(posedge pclk);
      #2;
   endtask

   always @(posedge pclk) begin
      obs_t e;
      #1;
      if (sq.size() > 0) begin
         e = sq.pop_front();
         vectors++;
         if (s_obs !== e) begin
            miscompares++;
            $display("FAIL sb_small got=%h exp=%h", s_obs, e);
         end
      end
      if (dq.size() > 0) begin
         e = dq.pop_front();
         vectors++;
         if (d_obs !== e) begin
            miscompares++;
            $display("FAIL sb_800x600 got=%h exp=%h", d_obs, e);
         end
      end
   end

   task automatic model_reset();
      sh = 0; sv = 0; sfc = 0;
      dh = 0; dv = 0; dfc = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b1;
      repeat (3) @(posedge pclk);
      #2;
      vectors++;
      if (s_obs !== RST_S) begin
         miscompares++;
         $display("FAIL reset_small got=%h exp=%h", s_obs, RST_S);
      end
      vectors++;
      if (d_obs !== RST_D) begin
         miscompares++;
         $display("FAIL reset_800x600 got=%h exp=%h", d_obs, RST_D);
      end
      en = 1'b0;
      rst_n = 1'b1;
      model_reset();
      step(1'b1);
      vectors++;
      if (s_h !== 11'd1) begin
         miscompares++;
         $display("FAIL first_en_hcount got=%0d exp=1", s_h);
      end
   endtask

   task automatic test_line();
      int hs_cnt = 0, hs_first = -1, hb_first = -1, eol_cnt = 0;
      for (int i = 0; i < DHT - 1; i++) begin
         step(1'b1);
         if (d_hs === 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(d_h);
         end
         if (d_hb === 1'b1 && hb_first < 0) hb_first = int'(d_h);
         if (d_eol === 1'b1) eol_cnt++;
      end
      vectors++;
      if (hs_cnt != DHS || hs_first != DHA + DHF) begin
         miscompares++;
         $display("FAIL hsync_window got=%0d@%0d exp=%0d@%0d", hs_cnt, hs_first, DHS, DHA + DHF);
      end
      vectors++;
      if (hb_first != DHA) begin
         miscompares++;
         $display("FAIL hblnk_start got=%0d exp=%0d", hb_first, DHA);
      end
      vectors++;
      if (eol_cnt != 1) begin
         miscompares++;
         $display("FAIL eol_per_line got=%0d exp=1", eol_cnt);
      end
      vectors++;
      if (d_h !== 11'd0 || d_v !== 11'd1) begin
         miscompares++;
         $display("FAIL line_wrap got=(%0d,%0d) exp=(0,1)", d_h, d_v);
      end
   endtask

   task automatic test_frame();
      int bound = 0, eof_cnt = 0, vs_lines = 0, vs_first = -1, fc0;
      while (!(sh == 0 && sv == 0) && bound < 2 * SHT * SVT) begin
         step(1'b1);
         bound++;
      end
      vectors++;
      if (!(sh == 0 && sv == 0)) begin
         miscompares++;
         $display("FAIL frame_align got=(%0d,%0d) exp=(0,0)", sh, sv);
      end
      fc0 = sfc;
      for (int i = 0; i < 3 * SHT * SVT; i++) begin
         step(1'b1);
         if (s_eof === 1'b1) eof_cnt++;
         if (s_vs === 1'b1 && s_h === 11'd0) begin
            vs_lines++;
            if (vs_first < 0) vs_first = int'(s_v);
         end
      end
      vectors++;
      if (eof_cnt != 3) begin
         miscompares++;
         $display("FAIL eof_pulses got=%0d exp=3", eof_cnt);
      end
      vectors++;
      if (vs_lines != 3 * SVS || vs_first != SVA + SVF) begin
         miscompares++;
         $display("FAIL vsync_window got=%0d@%0d exp=%0d@%0d", vs_lines, vs_first, 3 * SVS, SVA + SVF);
      end
      vectors++;
      if (s_h !== 11'd0 || s_v !== 11'd0) begin
         miscompares++;
         $display("FAIL frame_wrap got=(%0d,%0d) exp=(0,0)", s_h, s_v);
      end
      if (FC_ON) begin
         vectors++;
         if (s_fc !== 16'(fc0 + 3)) begin
            miscompares++;
            $display("FAIL frame_cnt got=%0d exp=%0d", s_fc, 16'(fc0 + 3));
         end
      end
   endtask

   task automatic test_enable();
      int bound = 0;
      logic [10:0] exp_h [4] = '{11'd11, 11'd11, 11'd11, 11'd12};
      logic        pat   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      while (sh != 10 && bound < 2 * SHT) begin
         step(1'b1);
         bound++;
      end
      for (int i = 0; i < 4; i++) begin
         step(pat[i]);
         vectors++;
         if (s_h !== exp_h[i]) begin
            miscompares++;
            $display("FAIL en_hold_%0d got=%0d exp=%0d", i, s_h, exp_h[i]);
         end
      end
   endtask

   task automatic test_midframe_reset();
      int bound = 0;
      while (!(sh == 20 && sv == 7) && bound < 2 * SHT * SVT) begin
         step(1'b1);
         bound++;
      end
      en = 1'b1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (s_obs !== RST_S) begin
         miscompares++;
         $display("FAIL async_reset_small got=%h exp=%h", s_obs, RST_S);
      end
      vectors++;
      if (d_obs !== RST_D) begin
         miscompares++;
         $display("FAIL async_reset_800x600 got=%h exp=%h", d_obs, RST_D);
      end
      @(posedge pclk);
      #2;
      vectors++;
      if (s_obs !== RST_S) begin
         miscompares++;
         $display("FAIL reset_hold got=%h exp=%h", s_obs, RST_S);
      end
      rst_n = 1'b1;
      model_reset();
      step(1'b1);
      step(1'b1);
      vectors++;
      if (s_h !== 11'd2 || s_v !== 11'd0) begin
         miscompares++;
         $display("FAIL post_reset got=(%0d,%0d) exp=(2,0)", s_h, s_v);
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_enable();
      test_midframe_reset();
      @(posedge pclk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_timing_param.md
# vga_timing_param

Parametrised VGA timing generator producing horizontal and vertical pixel counters, sync and blanking strobes for any mode defined by front porch/sync/back porch parameters. It replaces single-axis counting with a complete, mode-agnostic raster source and feeds the drawing and colouring stages of the VGA pipeline. All outputs are registered and mutually aligned on `pclk`.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch (pixels)
- `H_SYNC`, 128, hsync pulse width (pixels)
- `H_BP`, 88, horizontal back porch (pixels)
- `V_ACTIVE`, 600, visible lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vsync pulse width (lines)
- `V_BP`, 23, vertical back porch (lines)
- `HSYNC_POL`, 1, 1 = hsync active-high, 0 = active-low
- `VSYNC_POL`, 1, 1 = vsync active-high, 0 = active-low
- `CNT_W`, 11, counter width; must satisfy 2^CNT_W >= max(H_TOT, V_TOT)

- `pclk` in 1 pixel clock, all logic on rising edge
- `rst_n` in 1 asynchronous, active-low reset
- `en` in 1 pixel advance enable; low freezes every register
- `hcount` out CNT_W current pixel column, 0..H_TOT-1
- `vcount` out CNT_W current line, 0..V_TOT-1
- `hsync` out 1 horizontal sync, polarity per HSYNC_POL
- `vsync` out 1 vertical sync, polarity per VSYNC_POL
- `hblnk` out 1 high when hcount >= H_ACTIVE
- `vblnk` out 1 high when vcount >= V_ACTIVE
- `end_of_line` out 1 high while hcount == H_TOT-1
- `end_of_frame` out 1 high while hcount == H_TOT-1 and vcount == V_TOT-1
- `frame_cnt` out 16 frames completed (only with VGA_TIMING_FRAME_CNT_EN)

## Operation
- H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise.
- On `en`: hcount increments; at H_TOT-1 wraps to 0 and vcount increments; vcount wraps to 0 at V_TOT-1 when hcount also at H_TOT-1.
- hsync active while hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync active while vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; inactive level = ~POL.
- Strobes computed from next-state counts and registered, so every output describes the same pixel as the registered hcount/vcount.
- `en` low: counts and strobes hold; no wrap, no frame increment.
- All arithmetic unsigned CNT_W bits; comparisons against parameter-derived constants, no runtime division.

## Timing
- Reset (async assert, sync release on next `pclk`): hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, end_of_line=0, end_of_frame=0, frame_cnt=0.
- First `en` cycle after reset release: hcount=1.
- Latency: outputs change one `pclk` after the enabled edge that advances the counters; zero skew between outputs.
- Reset mid-frame: immediate return to reset values, regardless of `en`.
- end_of_line lasts exactly one enabled pixel; end_of_frame coincides with the last end_of_line of the frame.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: `frame_cnt` port present; increments (mod 2^16) on the enabled edge where hcount and vcount both wrap to 0.
- Not defined: port and register absent; all other behaviour identical.

## Structure
- `vga_pkg`: default 800x600@60 timing constants, derived totals, `CNT_W`-independent mode typedef.
- Sub-module `vga_axis_counter` (params: TOT, ACTIVE, SYNC_START, SYNC_LEN, POL, W; ports: clk, rst_n, en, inc, count, sync, blnk, last), instantiated once per axis; top wires h `last` into v `inc`.

## Test plan
- Release reset with en=1 for 1056 cycles -> hcount 0..1055 then 0, end_of_line high only at hcount=1055, vcount=1.
- Scan hcount 800..1055 -> hblnk=1 from 800; hsync=1 exactly for hcount 840..967.
- Run full frame (1056*628 cycles) -> vsync=1 for vcount 601..604, end_of_frame single pulse at (1055,627), then (0,0).
- en toggled 1-0-0-1 at hcount=500 -> hcount 501,501,501,502; strobes unchanged while low.
- rst_n asserted at hcount=300, vcount=200 -> all outputs at reset values before next `pclk`; HSYNC_POL=0 build -> hsync idles at 1.
- With VGA_TIMING_FRAME_CNT_EN, 3 full frames -> frame_cnt=3; preload near 16'hFFFF -> wraps to 0.
